// File: rtl/main_memory_controller_if.sv
// Request/response bus between the I/D requesters, the controller and the byte-wide RAM.
interface main_memory_controller_if #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LEN        = 32,
    parameter int unsigned BYTE_SIZE  = 8
);
    logic [1:0]            inst_vis_signal;
    logic [ADDR_WIDTH-1:0] inst_vis_addr;
    logic [1:0]            data_vis_signal;
    logic [ADDR_WIDTH-1:0] data_vis_addr;
    logic [1:0]            data_vis_size;
    logic [LEN-1:0]        data_wdata;
    logic [LEN-1:0]        mem_data;
    logic [1:0]            mem_status;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [BYTE_SIZE-1:0]  ram_wdata;
    logic [BYTE_SIZE-1:0]  ram_rdata;

    modport slave (
        input  inst_vis_signal, inst_vis_addr,
        input  data_vis_signal, data_vis_addr, data_vis_size, data_wdata,
        input  ram_rdata,
        output mem_data, mem_status, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output inst_vis_signal, inst_vis_addr,
        output data_vis_signal, data_vis_addr, data_vis_size, data_wdata,
        output ram_rdata,
        input  mem_data, mem_status, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/main_memory_controller.sv
// Serialises word/halfword/byte requests from the I- and D-side onto a byte-wide RAM,
// data side winning ties; reads are packed big-endian into mem_data.
module main_memory_controller #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LEN        = 32,
    parameter int unsigned BYTE_SIZE  = 8
) (
    input  logic clk,
    input  logic rst_n,
    main_memory_controller_if.slave bus
);
    localparam int unsigned WORD_BYTES = LEN / BYTE_SIZE;
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES + 1);

    localparam logic [1:0] SIG_READ    = 2'b01;
    localparam logic [1:0] SIG_WRITE   = 2'b10;
    localparam logic [1:0] ST_RESTING  = 2'b00;
    localparam logic [1:0] ST_INST     = 2'b01;
    localparam logic [1:0] ST_BUSY     = 2'b10;
    localparam logic [1:0] ST_DATA_FIN = 2'b11;

    typedef enum logic [2:0] {IDLE, INST_RD, DATA_RD, DATA_WR, DONE} state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [CNT_W-1:0]      nbytes, nbytes_d;
    logic [LEN-1:0]        rbuf, rbuf_d, rbuf_fill;
    logic [LEN-1:0]        wbuf, wbuf_d;
    logic [LEN-1:0]        mem_data_d;
    logic [1:0]            status_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  we_d;
    logic [BYTE_SIZE-1:0]  wdata_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            nbytes         <= '0;
            rbuf           <= '0;
            wbuf           <= '0;
            bus.mem_data   <= '0;
            bus.mem_status <= ST_RESTING;
            bus.ram_addr   <= '0;
            bus.ram_we     <= 1'b0;
            bus.ram_wdata  <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            nbytes         <= nbytes_d;
            rbuf           <= rbuf_d;
            wbuf           <= wbuf_d;
            bus.mem_data   <= mem_data_d;
            bus.mem_status <= status_d;
            bus.ram_addr   <= addr_d;
            bus.ram_we     <= we_d;
            bus.ram_wdata  <= wdata_d;
        end
    end

    // cnt = bytes addressed so far; the byte for address cnt-1 is on ram_rdata now
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        nbytes_d   = nbytes;
        rbuf_d     = rbuf;
        wbuf_d     = wbuf;
        mem_data_d = bus.mem_data;
        status_d   = bus.mem_status;
        addr_d     = bus.ram_addr;
        we_d       = 1'b0;
        wdata_d    = '0;
        rbuf_fill  = rbuf | (LEN'(bus.ram_rdata) << (LEN - BYTE_SIZE * 32'(cnt)));

        case (state)
            IDLE: begin
                status_d = ST_RESTING;
                cnt_d    = '0;
                if (bus.data_vis_signal == SIG_READ || bus.data_vis_signal == SIG_WRITE) begin
                    status_d = ST_BUSY;
                    cnt_d    = CNT_W'(1);
                    addr_d   = bus.data_vis_addr;
                    rbuf_d   = '0;
                    nbytes_d = (bus.data_vis_size == 2'b00) ? CNT_W'(1) :
                               (bus.data_vis_size == 2'b01) ? CNT_W'(2) : CNT_W'(WORD_BYTES);
                    if (bus.data_vis_signal == SIG_WRITE) begin
                        we_d    = 1'b1;
                        wdata_d = bus.data_wdata[LEN-1 -: BYTE_SIZE];
                        wbuf_d  = bus.data_wdata << BYTE_SIZE;
                        state_d = DATA_WR;
                    end else begin
                        state_d = DATA_RD;
                    end
                end else if (bus.inst_vis_signal == SIG_READ) begin
                    status_d = ST_BUSY;
                    cnt_d    = CNT_W'(1);
                    addr_d   = bus.inst_vis_addr;
                    rbuf_d   = '0;
                    nbytes_d = CNT_W'(WORD_BYTES);
                    state_d  = INST_RD;
                end
            end
            INST_RD, DATA_RD: begin
                if (cnt == nbytes) begin
                    mem_data_d = rbuf_fill;
                    status_d   = (state == INST_RD) ? ST_INST : ST_DATA_FIN;
                    state_d    = DONE;
                end else begin
                    rbuf_d = rbuf_fill;
                    addr_d = bus.ram_addr + ADDR_WIDTH'(1);
                    cnt_d  = cnt + CNT_W'(1);
                end
            end
            DATA_WR: begin
                if (cnt == nbytes) begin
                    status_d = ST_DATA_FIN;
                    state_d  = DONE;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = wbuf[LEN-1 -: BYTE_SIZE];
                    wbuf_d  = wbuf << BYTE_SIZE;
                    addr_d  = bus.ram_addr + ADDR_WIDTH'(1);
                    cnt_d   = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                status_d = ST_RESTING;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_main_memory_controller.sv
// Randomised bench for main_memory_controller: byte RAM model plus a transaction-level
// reference of expected status/data/write strobes, checked every falling edge.
module tb_main_memory_controller;
    localparam int unsigned AW    = 17;
    localparam int unsigned LW    = 32;
    localparam int unsigned BW    = 8;
    localparam int unsigned MEMSZ = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    main_memory_controller_if #(.ADDR_WIDTH(AW), .LEN(LW), .BYTE_SIZE(BW)) bus();
    main_memory_controller #(.ADDR_WIDTH(AW), .LEN(LW), .BYTE_SIZE(BW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] init_byte(input int unsigned i);
        case (i)
            32'h100:   return 8'h13;
            32'h101:   return 8'h00;
            32'h102:   return 8'h00;
            32'h103:   return 8'h93;
            32'h1FFFF: return 8'h5A;
            32'h0:     return 8'hC3;
            default:   return 8'(i * 7 + 3);
        endcase
    endfunction

    // Byte RAM: combinational read, write on rising edge
    logic [7:0] ram [0:MEMSZ-1];
    bit ram_loaded = 1'b0;
    assign bus.ram_rdata = ram[bus.ram_addr];
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < int'(MEMSZ); i++) ram[i] <= init_byte(i);
            ram_loaded <= 1'b1;
        end else if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    // Transaction-level reference: m_t counts edges since acceptance
    logic [7:0]  ref_mem [0:MEMSZ-1];
    bit          ref_loaded = 1'b0;
    logic [1:0]  e_status;
    logic [31:0] e_data;
    logic        e_we;
    logic [16:0] e_addr;
    logic [7:0]  e_wdata;
    bit          m_active, m_inst, m_write, pend_v;
    int          m_t, m_n;
    logic [16:0] m_a, pend_a;
    logic [31:0] m_wd;
    logic [7:0]  pend_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!ref_loaded) begin
                for (int i = 0; i < int'(MEMSZ); i++) ref_mem[i] = init_byte(i);
                ref_loaded = 1'b1;
            end
            m_active = 0; pend_v = 0;
            e_status = 2'b00; e_data = '0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        end else begin
            if (pend_v) begin ref_mem[pend_a] = pend_d; pend_v = 0; end
            e_we = 1'b0;
            if (m_active) begin
                m_t++;
            end else if (bus.data_vis_signal == 2'b01 || bus.data_vis_signal == 2'b10) begin
                m_active = 1; m_t = 0; m_inst = 0;
                m_write = (bus.data_vis_signal == 2'b10);
                m_a = bus.data_vis_addr; m_wd = bus.data_wdata;
                m_n = (bus.data_vis_size >= 2'd2) ? 4 : int'(bus.data_vis_size) + 1;
            end else if (bus.inst_vis_signal == 2'b01) begin
                m_active = 1; m_t = 0; m_inst = 1; m_write = 0;
                m_a = bus.inst_vis_addr; m_n = 4;
            end
            if (m_active) begin
                if (m_t < m_n) begin
                    e_status = 2'b10;
                    if (m_write) begin
                        e_we = 1'b1;
                        e_addr = m_a + 17'(m_t);
                        e_wdata = 8'(m_wd >> (24 - 8 * m_t));
                        pend_v = 1; pend_a = e_addr; pend_d = e_wdata;
                    end
                end else if (m_t == m_n) begin
                    e_status = m_inst ? 2'b01 : 2'b11;
                    if (!m_write) begin
                        e_data = '0;
                        for (int k = 0; k < m_n; k++)
                            e_data = e_data | (32'(ref_mem[m_a + 17'(k)]) << (24 - 8 * k));
                    end
                end else begin
                    m_active = 0;
                    e_status = 2'b00;
                end
            end else begin
                e_status = 2'b00;
            end
        end
    end

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        if (ref_loaded) begin
            chk("mem_status", 64'(bus.mem_status), 64'(e_status));
            chk("mem_data", 64'(bus.mem_data), 64'(e_data));
            chk("ram_we", 64'(bus.ram_we), 64'(e_we));
            if (!rst_n) begin
                chk("ram_addr_reset", 64'(bus.ram_addr), 64'(0));
            end else if (e_we) begin
                chk("ram_addr_wr", 64'(bus.ram_addr), 64'(e_addr));
                chk("ram_wdata", 64'(bus.ram_wdata), 64'(e_wdata));
            end
        end
    end

    task automatic set_nop();
        bus.inst_vis_signal = 2'b00; bus.inst_vis_addr = '0;
        bus.data_vis_signal = 2'b00; bus.data_vis_addr = '0;
        bus.data_vis_size = 2'b00; bus.data_wdata = '0;
    endtask

    // Present a request across exactly one rising edge
    task automatic issue(input logic [1:0] is, input logic [16:0] ia, input logic [1:0] ds,
                         input logic [16:0] da, input logic [1:0] dz, input logic [31:0] dw);
        @(negedge clk);
        bus.inst_vis_signal = is; bus.inst_vis_addr = ia;
        bus.data_vis_signal = ds; bus.data_vis_addr = da;
        bus.data_vis_size = dz; bus.data_wdata = dw;
        @(negedge clk);
        set_nop();
    endtask

    task automatic wait_done(output logic [1:0] st, output int busy);
        bit done = 0;
        busy = 0; st = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_status == 2'b01 || bus.mem_status == 2'b11) begin
                st = bus.mem_status; done = 1;
            end
            if (done) break;
            if (bus.mem_status == 2'b10) busy++;
            @(negedge clk);
        end
    endtask

    logic [1:0] st;
    int         busy, comps;

    initial begin
        set_nop();
        repeat (2) @(negedge clk);
        chk("reset_status", 64'(bus.mem_status), 64'(0));
        chk("reset_data", 64'(bus.mem_data), 64'(0));
        chk("reset_we", 64'(bus.ram_we), 64'(0));
        #2 rst_n = 1'b1;

        // Instruction word fetch
        issue(2'b01, 17'h100, 2'b00, 17'h0, 2'b00, 32'h0);
        wait_done(st, busy);
        chk("inst_status", 64'(st), 64'(2'b01));
        chk("inst_busy_cycles", 64'(busy), 64'(4));
        chk("inst_data", 64'(bus.mem_data), 64'(32'h13000093));
        @(negedge clk);
        chk("inst_resting", 64'(bus.mem_status), 64'(2'b00));

        // Word write then read back
        issue(2'b00, 17'h0, 2'b10, 17'h200, 2'b10, 32'hAABBCCDD);
        wait_done(st, busy);
        chk("wr_status", 64'(st), 64'(2'b11));
        chk("wr_busy_cycles", 64'(busy), 64'(4));
        chk("wr_data_held", 64'(bus.mem_data), 64'(32'h13000093));
        chk("wr_ram", 64'({ram[17'h200], ram[17'h201], ram[17'h202], ram[17'h203]}), 64'(32'hAABBCCDD));
        issue(2'b00, 17'h0, 2'b01, 17'h200, 2'b11, 32'h0);
        wait_done(st, busy);
        chk("rd_back", 64'(bus.mem_data), 64'(32'hAABBCCDD));

        // Simultaneous requests: data byte read wins, instruction re-issued
        issue(2'b01, 17'h100, 2'b01, 17'h203, 2'b00, 32'h0);
        wait_done(st, busy);
        chk("tie_status", 64'(st), 64'(2'b11));
        chk("tie_busy_cycles", 64'(busy), 64'(1));
        chk("tie_data", 64'(bus.mem_data), 64'(32'hDD000000));
        issue(2'b01, 17'h100, 2'b00, 17'h0, 2'b00, 32'h0);
        wait_done(st, busy);
        chk("reissue_status", 64'(st), 64'(2'b01));
        chk("reissue_data", 64'(bus.mem_data), 64'(32'h13000093));

        // Halfword read across the address wrap
        issue(2'b00, 17'h0, 2'b01, 17'h1FFFF, 2'b01, 32'h0);
        wait_done(st, busy);
        chk("wrap_data", 64'(bus.mem_data), 64'(32'h5AC30000));

        // Reset during the third byte of a word write
        issue(2'b00, 17'h0, 2'b10, 17'h300, 2'b10, 32'h11223344);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", 64'(bus.ram_we), 64'(0));
        chk("abort_status", 64'(bus.mem_status), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        chk("abort_ram", 64'({ram[17'h300], ram[17'h301], ram[17'h302]}),
            64'({8'h11, 8'h22, init_byte(32'h302)}));
        comps = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.mem_status == 2'b11) comps++;
        end
        chk("abort_no_finish", 64'(comps), 64'(0));
        issue(2'b00, 17'h0, 2'b01, 17'h300, 2'b01, 32'h0);
        wait_done(st, busy);
        chk("after_abort_data", 64'(bus.mem_data), 64'(32'h11220000));

        // Instruction request while busy is dropped
        issue(2'b01, 17'h100, 2'b00, 17'h0, 2'b00, 32'h0);
        issue(2'b01, 17'h104, 2'b00, 17'h0, 2'b00, 32'h0);
        comps = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_status == 2'b01) comps++;
            @(negedge clk);
        end
        chk("busy_drop_pulses", 64'(comps), 64'(1));
        chk("busy_drop_data", 64'(bus.mem_data), 64'(32'h13000093));

        // Randomised traffic including illegal codes and occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            bus.inst_vis_signal = ($urandom % 3 == 0) ? 2'($urandom) : 2'b00;
            bus.inst_vis_addr   = ($urandom % 4 == 0) ? 17'h1FFFF - 17'($urandom % 3) : 17'($urandom);
            bus.data_vis_signal = ($urandom % 3 == 0) ? 2'($urandom) : 2'b00;
            bus.data_vis_addr   = ($urandom % 4 == 0) ? 17'h1FFFF - 17'($urandom % 3) : 17'($urandom % 1024);
            bus.data_vis_size   = 2'($urandom);
            bus.data_wdata      = $urandom;
            if ($urandom % 150 == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        set_nop();
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
